// File: rtl/rf_pkg.sv
// rf_pkg: shared address type and sizing constants for the register file
package rf_pkg;
  localparam int ADDR_W = 5;
  localparam int NREGS_MAX = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/rf_entry.sv
// rf_entry: one WIDTH-bit register with asynchronous reset and write enable
module rf_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_d, q_q;
  always_comb q_d = we_i ? d_i : q_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W register file with x0 hardwired to zero; define RF_BYPASS_EN to forward same-edge writes to reads
module reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  addr_t            wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  addr_t            ra1,
  input  addr_t            ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rvalid
);
  logic [WIDTH-1:0] regs [NREGS_MAX];
  logic [WIDTH-1:0] rv1, rv2, rd1_d, rd1_q, rd2_d, rd2_q;
  logic             rvalid_q;
  // x0 and indices beyond NREGS are constant zero, so writes there vanish and reads return 0
  for (genvar i = 0; i < NREGS_MAX; i++) begin : g_reg
    if (i > 0 && i < NREGS) begin : g_ent
      rf_entry #(.WIDTH(WIDTH)) u_ent (
        .clk  (clk),
        .reset(reset),
        .we_i (we && wa == addr_t'(i)),
        .d_i  (wd),
        .q_o  (regs[i])
      );
    end else begin : g_zero
      assign regs[i] = '0;
    end
  end
`ifdef RF_BYPASS_EN
  logic wr_ok;
  assign wr_ok = we && wa != ZERO_ADDR && int'(wa) < NREGS;
  assign rv1 = (wr_ok && ra1 == wa) ? wd : regs[ra1];
  assign rv2 = (wr_ok && ra2 == wa) ? wd : regs[ra2];
`else
  assign rv1 = regs[ra1];
  assign rv2 = regs[ra2];
`endif
  always_comb begin
    rd1_d = re ? rv1 : rd1_q;
    rd2_d = re ? rv2 : rd2_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd1_q    <= '0;
      rd2_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rvalid_q <= re;
    end
  assign rd1    = rd1_q;
  assign rd2    = rd2_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1, rd2;
  logic        rvalid;
  int          n_tests = 0;
  int          n_fail = 0;
`ifdef RF_BYPASS_EN
  localparam logic [31:0] SAME_EDGE_EXP = 32'd25;
`else
  localparam logic [31:0] SAME_EDGE_EXP = 32'd15;
`endif

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .re    (re),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    we = 1'b1; wa = 5'd4; wd = 32'd99; re = 1'b1; ra1 = 5'd4;
    tick();
    tick();
    chk("in_reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("in_reset_rd1", rd1, 32'd0);
    reset = 1'b0; we = 1'b0; re = 1'b0;
    tick();
    chk("post_reset_rvalid", {31'd0, rvalid}, 32'd0);
    re = 1'b1; ra1 = 5'd4; ra2 = 5'd0;
    tick();
    chk("reset_write_ignored", rd1, 32'd0);
    ra1 = 5'd5; ra2 = 5'd0;
    tick();
    re = 1'b0;
    chk("first_read_rd1", rd1, 32'd0);
    chk("first_read_rd2", rd2, 32'd0);
    chk("first_read_rvalid", {31'd0, rvalid}, 32'd1);
    wr(5'd5, 32'h0000_0014);
    re = 1'b1; ra1 = 5'd5; ra2 = 5'd5;
    tick();
    re = 1'b0;
    chk("x5_rd1", rd1, 32'd20);
    chk("x5_same_addr_rd2", rd2, 32'd20);
    chk("x5_rvalid", {31'd0, rvalid}, 32'd1);
    tick();
    chk("idle_rvalid_drop", {31'd0, rvalid}, 32'd0);
    chk("idle_rd1_hold", rd1, 32'd20);
    wr(5'd0, 32'hFFFF_FFFF);
    re = 1'b1; ra1 = 5'd0; ra2 = 5'd5;
    tick();
    re = 1'b0;
    chk("x0_after_write", rd1, 32'd0);
    chk("x0_other_port", rd2, 32'd20);
    we = 1'b1; wa = 5'd0; wd = 32'hAA; re = 1'b1; ra1 = 5'd0;
    tick();
    we = 1'b0; re = 1'b0;
    chk("x0_same_edge", rd1, 32'd0);
    wr(5'd7, 32'd15);
    we = 1'b1; wa = 5'd7; wd = 32'd25; re = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
    tick();
    we = 1'b0;
    chk("same_edge_rd1", rd1, SAME_EDGE_EXP);
    chk("same_edge_rd2", rd2, SAME_EDGE_EXP);
    tick();
    re = 1'b0;
    chk("after_same_edge", rd1, 32'd25);
    wr(5'd1, 32'd10);
    wr(5'd2, 32'd20);
    wr(5'd3, 32'd30);
    re = 1'b1; ra1 = 5'd1;
    tick();
    chk("burst0_rvalid", {31'd0, rvalid}, 32'd1);
    chk("burst0_rd1", rd1, 32'd10);
    ra1 = 5'd2;
    tick();
    chk("burst1_rvalid", {31'd0, rvalid}, 32'd1);
    chk("burst1_rd1", rd1, 32'd20);
    re = 1'b0; ra1 = 5'd3;
    tick();
    chk("burst2_rvalid", {31'd0, rvalid}, 32'd0);
    chk("burst2_rd1_held", rd1, 32'd20);
    re = 1'b1;
    tick();
    chk("burst3_rvalid", {31'd0, rvalid}, 32'd1);
    chk("burst3_rd1", rd1, 32'd30);
    ra1 = 5'd3; ra2 = 5'd1;
    tick();
    chk("pre_reset_rd2", rd2, 32'd10);
    #3 reset = 1'b1;
    #1;
    chk("async_rd1", rd1, 32'd0);
    chk("async_rd2", rd2, 32'd0);
    chk("async_rvalid", {31'd0, rvalid}, 32'd0);
    tick();
    chk("reset_burst_rvalid", {31'd0, rvalid}, 32'd0);
    reset = 1'b0; re = 1'b0;
    tick();
    chk("release_rvalid", {31'd0, rvalid}, 32'd0);
    chk("release_rd1", rd1, 32'd0);
    re = 1'b1; ra1 = 5'd3; ra2 = 5'd7;
    tick();
    re = 1'b0;
    chk("x3_cleared", rd1, 32'd0);
    chk("x7_cleared", rd2, 32'd0);
    chk("post_clear_rvalid", {31'd0, rvalid}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and port.
REQ-002 Parameter NREGS, default 32: number of registers; address width = 5.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 we  input  1  write enable, sampled at rising clk.
REQ-006 wa  input  5  write address.
REQ-007 wd  input  WIDTH  write data.
REQ-008 re  input  1  read request, sampled at rising clk.
REQ-009 ra1  input  5  read address, port 1.
REQ-010 ra2  input  5  read address, port 2.
REQ-011 rd1  output  WIDTH  registered read data, port 1.
REQ-012 rd2  output  WIDTH  registered read data, port 2.
REQ-013 rvalid  output  1  high for exactly one cycle when rd1/rd2 carry fresh data.

Function
REQ-014 Write: at rising clk with we=1 and wa!=0, array[wa] SHALL take wd.
REQ-015 Writes to address 0 SHALL be discarded; array[0] reads as 0 forever.
REQ-016 Read latency SHALL be one cycle: re=1 at edge N -> rd1/rd2 loaded at edge N, rvalid=1 from edge N until edge N+1.
REQ-017 With re=0 at an edge, rd1/rd2 SHALL hold their previous values and rvalid SHALL drop to 0.
REQ-018 Back-to-back re=1 SHALL keep rvalid high continuously, each cycle carrying the data for that cycle's addresses.
REQ-019 ra1==ra2 SHALL return identical data on both ports.
REQ-020 Read of address 0 SHALL return 0 regardless of any write to address 0.
REQ-021 Simultaneous write and read of the same nonzero address at one edge: behaviour per REQ-026/027.
REQ-022 Addresses >= NREGS (when NREGS<32): writes SHALL be discarded, reads SHALL return 0.

Reset
REQ-023 reset=1 SHALL, without waiting for clk, clear every array entry, rd1, rd2 to 0 and rvalid to 0.
REQ-024 A write or read request coinciding with a clk edge while reset=1 SHALL be ignored; operation resumes at the first edge after reset deasserts.
REQ-025 Reset asserted mid-burst of reads SHALL drop rvalid immediately; no stale data is presented after release.

Configuration
REQ-026 With RF_BYPASS_EN defined, a read of address A at the same edge as a write to A (A!=0) SHALL return the new wd.
REQ-027 Without RF_BYPASS_EN, that read SHALL return the value held before the write; the new value is visible from the next read.

Structure
REQ-028 Package rf_pkg SHALL hold ADDR_W=5, NREGS_MAX=32, ZERO_ADDR=0 and the address typedef.
REQ-029 One sub-module rf_entry (WIDTH-bit register with async reset and write enable) SHALL be instantiated per register index 1..NREGS-1.

Verification
REQ-030 Reset, then re=1 ra1=5 ra2=0 -> next cycle rd1=0, rd2=0, rvalid=1.
REQ-031 we=1 wa=5 wd=32'h0000_0014; next edge re=1 ra1=5 -> rd1=20, rvalid=1 one cycle.
REQ-032 we=1 wa=0 wd=32'hFFFF_FFFF, then read ra1=0 -> rd1=0.
REQ-033 Same edge we=1 wa=7 wd=25 (old value 15) with re=1 ra1=7 -> rd1=25 with RF_BYPASS_EN, rd1=15 without.
REQ-034 Write 30 to x3, assert reset mid-cycle between edges -> rd1, rd2, rvalid immediately 0; post-reset read of x3 -> 0.
REQ-035 re pulsed 1,1,0,1 with ra1=x1,x2,-,x3 holding 10,20,30 -> rvalid 1,1,0,1 and rd1 10,20,20(held),30.
